decade_counter: RTL and testbench

4-bit synchronous BCD (mod-10) up/down counter with synchronous parallel load, count enable and terminal-count output. Used as one decade stage. TC feeds the enable of the next stage to build multi-digit BCD counters.

---
 rtl/decade_counter_pkg.sv | 35 +++
 rtl/decade_counter_if.sv | 24 ++
 rtl/decade_counter.sv | 39 +++
 tb/tb_decade_counter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/decade_counter_pkg.sv
// Shared constants, direction type and next-count function for BCD decade stages.
package decade_counter_pkg;

    localparam int CNT_W   = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } count_dir_t;

    // Load wins over counting; out-of-range load values are forced to zero.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] data_in,
        input logic             load,
        input logic             counter_on,
        input count_dir_t       dir,
        input logic [CNT_W-1:0] max_c
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (load == 1'b1) begin
            nxt = (data_in > max_c) ? '0 : data_in;
        end else if (counter_on == 1'b1) begin
            if (dir == UP) begin
                nxt = (cnt == max_c) ? '0 : cnt + 1'b1;
            end else begin
                nxt = (cnt == '0) ? max_c : cnt - 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/decade_counter_if.sv
// Control/status bundle of one decade stage; the counter is the slave side.
interface decade_counter_if;
    import decade_counter_pkg::*;

    // Controls are level-sampled at each rising clk edge; TC and count are
    // valid every cycle with no handshake (TC is combinational on controls).
    logic             load;
    logic [CNT_W-1:0] data_in;
    logic             counter_on;
    logic             count_up;
    logic             TC;
    logic [CNT_W-1:0] count;

    modport master (
        output load, data_in, counter_on, count_up,
        input  TC, count
    );

    modport slave (
        input  load, data_in, counter_on, count_up,
        output TC, count
    );

endinterface

// File: rtl/decade_counter.sv
// One BCD decade: mod-(MAX_COUNT+1) up/down counter with load and terminal count.
module decade_counter
    import decade_counter_pkg::*;
#(
    parameter int MAX_COUNT = BCD_MAX
) (
    input  logic             clk,
    input  logic             reset,
    decade_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    count_dir_t       dir;

    assign dir = count_dir_t'(bus.count_up);

    always_comb begin
        count_d = next_count(count_q, bus.data_in, bus.load, bus.counter_on, dir, MAX_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High exactly in the cycle whose next edge wraps the count.
    assign bus.TC = bus.counter_on & ~bus.load &
                    ((bus.count_up & (count_q == MAX_C)) |
                     (~bus.count_up & (count_q == '0)));

    assign bus.count = count_q;

endmodule

// File: tb/tb_decade_counter.sv
// Bench for decade_counter: arithmetic mod-10 model, directed scenarios, random run and a two-digit cascade.
module tb_decade_counter;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decade_counter_if dut_if ();
    decade_counter_if lo_if ();
    decade_counter_if hi_if ();

    decade_counter #(.MAX_COUNT(9)) u_dut (.clk(clk), .reset(reset), .bus(dut_if));
    decade_counter #(.MAX_COUNT(9)) u_lo  (.clk(clk), .reset(reset), .bus(lo_if));
    decade_counter #(.MAX_COUNT(9)) u_hi  (.clk(clk), .reset(reset), .bus(hi_if));

    assign hi_if.counter_on = lo_if.TC;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    int m_count = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_tc(input int c, input logic ld, input logic en, input logic up);
        return (en === 1'b1) && (ld !== 1'b1) && ((up === 1'b1) ? (c == 9) : (c == 0));
    endfunction

    // Behavioural model: decimal digit arithmetic, load clamps illegal values to 0.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count <= 0;
        end else if (dut_if.load === 1'b1) begin
            m_count <= (int'(dut_if.data_in) > 9) ? 0 : int'(dut_if.data_in);
        end else if (dut_if.counter_on === 1'b1) begin
            m_count <= (dut_if.count_up === 1'b1) ? (m_count + 1) % 10 : (m_count + 9) % 10;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        check("model_count", 32'(dut_if.count), 32'(m_count));
        check("model_tc", 32'(dut_if.TC),
              32'(exp_tc(m_count, dut_if.load, dut_if.counter_on, dut_if.count_up)));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [3:0] d, input logic en, input logic up);
        dut_if.load       = ld;
        dut_if.data_in    = d;
        dut_if.counter_on = en;
        dut_if.count_up   = up;
    endtask

    task automatic drain_expected(input string name);
        logic [4:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            check({name, "_count"}, 32'(dut_if.count), 32'(e[3:0]));
            check({name, "_tc"}, 32'(dut_if.TC), 32'(e[4]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        drive(1'b1, 4'd6, 1'b0, 1'b1);
        lo_if.load = 1'b0; lo_if.data_in = 4'd0; lo_if.counter_on = 1'b0; lo_if.count_up = 1'b1;
        hi_if.load = 1'b0; hi_if.data_in = 4'd0; hi_if.count_up = 1'b1;

        // Reset held with load active: count stays 0, TC low.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_count", 32'(dut_if.count), 32'd0);
            check("rst_tc", 32'(dut_if.TC), 32'd0);
        end
        reset = 1'b1;

        // Load 8, then load 9 with counting enabled: TC masked by load.
        drive(1'b1, 4'd8, 1'b0, 1'b1);
        step();
        check("load8", 32'(dut_if.count), 32'd8);
        drive(1'b1, 4'd9, 1'b1, 1'b1);
        step();
        check("load9", 32'(dut_if.count), 32'd9);
        check("load9_tc", 32'(dut_if.TC), 32'd0);

        // Count up across the wrap.
        drive(1'b1, 4'd8, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        exp_q.push_back({1'b1, 4'd9});
        exp_q.push_back({1'b0, 4'd0});
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b0, 4'd2});
        drain_expected("up");

        // Asynchronous reset mid-count, checked between clock edges.
        reset = 1'b0;
        #1;
        check("async_rst", 32'(dut_if.count), 32'd0);
        #1;
        reset = 1'b1;

        // Count down across the wrap.
        drive(1'b1, 4'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 4'd0});
        exp_q.push_back({1'b0, 4'd9});
        exp_q.push_back({1'b0, 4'd8});
        drain_expected("down");

        // Hold at 5, then an illegal load value.
        drive(1'b1, 4'd5, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_count", 32'(dut_if.count), 32'd5);
            check("hold_tc", 32'(dut_if.TC), 32'd0);
        end
        drive(1'b1, 4'd12, 1'b1, 1'b0);
        step();
        check("illegal_load", 32'(dut_if.count), 32'd0);
        drive(1'b1, 4'd15, 1'b0, 1'b1);
        step();
        check("illegal_load15", 32'(dut_if.count), 32'd0);

        // Randomized run; the compare process checks every cycle.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            step();
        end

        // Two-digit cascade: low TC enables the high digit.
        lo_if.load = 1'b1; lo_if.data_in = 4'd0;
        hi_if.load = 1'b1; hi_if.data_in = 4'd0;
        step();
        lo_if.load = 1'b0; hi_if.load = 1'b0;
        lo_if.counter_on = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            check("casc_lo", 32'(lo_if.count), 32'(k % 10));
            check("casc_hi", 32'(hi_if.count), 32'((k / 10) % 10));
        end
        check("casc_final_lo", 32'(lo_if.count), 32'd5);
        check("casc_final_hi", 32'(hi_if.count), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
